// File: rtl/q_4phase_sink.sv
// Clocked sink for a 4-phase bundled-data pipeline: synchronises req, buffers
// each token in a small FIFO, returns ack and exposes tokens over valid/ready.
module q_4phase_sink #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic [WIDTH-1:0]         data,
  output logic                     ack,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              xfer_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    ACK_HI   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 ack_q, ack_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 req_s;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 out_valid_q, out_valid_d;
  logic [15:0]          xfer_count_q;
  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic                 push, pop, full, empty;

  // Synchroniser resets high so a req held across reset cannot look like a new rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req};
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign pop   = out_ready && !empty;

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    push    = 1'b0;
    case (state_q)
      WAIT_LOW: begin
        if (!req_s) state_d = IDLE;
      end
      IDLE: begin
        // Full check uses the registered count, so a same-edge pop never frees the slot.
        if (req_s && !full) begin
          push    = 1'b1;
          ack_d   = 1'b1;
          state_d = ACK_HI;
        end
      end
      ACK_HI: begin
        ack_d = 1'b1;
        if (!req_s) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = WAIT_LOW;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    out_valid_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_LOW;
      ack_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_count_q <= '0;
    end else if (push) begin
      xfer_count_q <= xfer_count_q + 16'd1;
    end
  end

  // Token storage carries no reset; contents are only meaningful while counted.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data;
  end

  assign ack        = ack_q;
  assign out_valid  = out_valid_q;
  assign out_data   = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign xfer_count = xfer_count_q;

endmodule

// File: doc/q_4phase_sink.md
Name: q_4phase_sink

Overview:
- Clocked responder terminating a self-timed 4-phase (return-to-zero) bundled-data pipeline.
- Receives req/data from the last q-flop stage's request output.
- Synchronises req into the local clock domain and buffers each token in a small FIFO.
- Returns ack per 4-phase rules and presents tokens to synchronous logic over a valid/ready port.

Parameters:
- WIDTH, 8, bundled data width.
- DEPTH, 4, FIFO entries (power of two, >=2).
- SYNC_STAGES, 2, flops in the req synchroniser (>=2).

Ports:
- clk  input  1  local clock.
- rst  input  1  synchronous, active-high reset.
- req  input  1  asynchronous 4-phase request from the upstream stage.
- data  input  WIDTH  bundled data; stable while req is high.
- ack  output  1  4-phase acknowledge to upstream; registered.
- out_valid  output  1  FIFO non-empty.
- out_data  output  WIDTH  FIFO head; valid when out_valid=1.
- out_ready  input  1  consumer pops the head on a clk edge where out_valid&out_ready.
- count  output  clog2(DEPTH)+1  current FIFO occupancy.
- xfer_count  output  16  completed handshakes (ack rising edges); wraps 0xFFFF->0.

Behaviour:
- Reset (rst sampled high at a clk edge):
  - ack=0, out_valid=0, count=0, xfer_count=0.
  - FIFO pointers=0.
  - All synchroniser flops set to 1.
  - FSM enters WAIT_LOW.
  - Applies mid-handshake; the in-flight token is dropped unless already pushed.
- Synchroniser: req_s = req delayed through SYNC_STAGES flops; no other logic samples raw req.
- FSM states:
  - WAIT_LOW: ack=0. Go to IDLE when req_s=0. Prevents a stale high req after reset being taken as a new token.
  - IDLE: ack=0.
    - If req_s=1 and count<DEPTH: push data at this edge, go to ACK_HI; ack=1 from this edge.
    - If req_s=1 and count==DEPTH: stay in IDLE (upstream stalls, ack held low).
  - ACK_HI: ack=1. When req_s=0, go to IDLE and set ack=0.
- Token data is sampled directly from the data port at the IDLE->ACK_HI edge. Bundling margin is covered by the synchroniser delay.
- Latency, SYNC_STAGES=2, FIFO not full: first edge sampling req=1 is edge E.
  - req_s=1 after E+1.
  - Push, and ack=1, after E+2.
  - Token visible on out_valid after E+2 if the FIFO was empty; no bypass, same edge as the push.
- Return-to-zero: first edge sampling req=0 is edge F; ack=0 after F+2.
- xfer_count increments on the IDLE->ACK_HI edge.
- FIFO:
  - Circular buffer, read/write pointers wrap modulo DEPTH.
  - Full/empty are derived from registered count.
  - Push and pop on the same edge: both occur and count is unchanged.
  - When count==DEPTH, a same-edge pop does not enable the push. Push is retried on the next edge with the updated count.
  - Pop when empty is ignored; out_data is don't-care when out_valid=0.
- out_valid = (count!=0), registered with count.
- Protocol violation (upstream drops data early) is not detected; the upstream must honour bundling.

Test Plan:
- Reset release with req held high:
  - rst=1 then 0, req=1 for 10 cycles -> ack stays 0 and count=0.
  - Drop req; assert req with data=0x5A -> ack=1 after 3 edges, out_data=0x5A, xfer_count=1.
- Single 4-phase cycle, out_ready=1, SYNC_STAGES=2:
  - req rises before edge E -> ack=1 after E+2 with out_valid=1 for one cycle.
  - req falls before F -> ack=0 after F+2.
- Fill and stall, out_ready=0:
  - Send 4 tokens 0x01..0x04 -> count=4.
  - Fifth req -> ack stays 0 for 20 cycles.
  - Set out_ready=1 for one edge -> pops 0x01, count=3. Next eligible edge pushes the 5th token and ack=1.
- Simultaneous push/pop:
  - Start count=2, out_ready=1, push edge coincides with pop -> count stays 2.
  - Output order is preserved (0x10, 0x11, 0x12); pointer wrap is exercised over 12 tokens.
- Reset mid-handshake:
  - In ACK_HI with req=1, pulse rst -> ack=0 next edge, count=0.
  - Hold req=1 -> no new push until req returns low and rises again.
- xfer_count wrap: preload via 65537 handshakes (or forced state) -> xfer_count reads 0x0001 after 0xFFFF+2 handshakes.
